aligner_apb_regs: RTL

APB3 slave register block for the aligner. It consumes the transfers the testbench APB interface drives: psel/penable/pwrite/paddr/pwdata in, prdata/pready/pslverr out. It holds the aligner configuration (SIZE, OFFSET, CLR pulse), exposes FIFO levels read-only, and owns the interrupt enable/status registers and the irq output. Wait-state insertion is programmable so the bench can exercise pready stalls.

---
 rtl/aligner_apb_regs.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/aligner_apb_regs.sv
// APB3 slave register block for the aligner: CTRL config, FIFO level status,
// interrupt enable/status and registered irq output, with programmable wait states.
module aligner_apb_regs #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned LVL_W       = 4
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [15:0]      paddr,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             pready,
  output logic             pslverr,
  output logic [2:0]       cfg_size_o,
  output logic [1:0]       cfg_offset_o,
  output logic             cfg_clr_o,
  input  logic [LVL_W-1:0] rx_lvl_i,
  input  logic [LVL_W-1:0] tx_lvl_i,
  input  logic [4:0]       irq_event_i,
  output logic             irq_o
);

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  localparam logic [13:0] A_CTRL   = 14'h0000;
  localparam logic [13:0] A_STATUS = 14'h0003;
  localparam logic [13:0] A_IRQEN  = 14'h003C;
  localparam logic [13:0] A_IRQ    = 14'h003D;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  offset_q, offset_d;
  logic        clr_q, clr_d;
  logic [4:0]  irqen_q, irqen_d;
  logic [4:0]  irq_q, irq_d;
  logic        irq_o_q, irq_o_d;

  logic        sel_ctrl, sel_status, sel_irqen, sel_irq;
  logic        ctrl_legal, access_err, commit;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{paddr[1:0], wdata_q[31:17], wdata_q[15:10], wdata_q[7:5]};

  // Decode and responses depend only on latched transfer state and registers.
  always_comb begin
    sel_ctrl   = (addr_q == A_CTRL);
    sel_status = (addr_q == A_STATUS);
    sel_irqen  = (addr_q == A_IRQEN);
    sel_irq    = (addr_q == A_IRQ);
    case (wdata_q[2:0])
      3'd1:    ctrl_legal = 1'b1;
      3'd2:    ctrl_legal = ~wdata_q[8];
      3'd4:    ctrl_legal = (wdata_q[9:8] == 2'd0);
      default: ctrl_legal = 1'b0;
    endcase
    access_err = ~(sel_ctrl | sel_status | sel_irqen | sel_irq)
               | (write_q & sel_status)
               | (write_q & sel_ctrl & ~ctrl_legal);
    rdata = '0;
    if (sel_ctrl)   rdata = {22'd0, offset_q, 5'd0, size_q};
    if (sel_status) rdata = 32'(rx_lvl_i) | (32'(tx_lvl_i) << 8);
    if (sel_irqen)  rdata = {27'd0, irqen_q};
    if (sel_irq)    rdata = {27'd0, irq_q};
    pready  = (state_q == S_ACCESS) && (cnt_q == 4'd0);
    pslverr = pready & access_err;
    prdata  = (pready & ~write_q & ~access_err) ? rdata : '0;
    commit  = pready & psel & penable;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    offset_d = offset_q;
    irqen_d  = irqen_q;
    irq_d    = irq_q;
    clr_d    = 1'b0;
    irq_o_d  = |(irq_q & irqen_q);
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          state_d = S_ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          addr_d  = paddr[15:2];
          write_d = pwrite;
          wdata_d = pwdata;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (penable) begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          else               state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit && write_q && !access_err) begin
      if (sel_ctrl) begin
        size_d   = wdata_q[2:0];
        offset_d = wdata_q[9:8];
        clr_d    = wdata_q[16];
      end
      if (sel_irqen) irqen_d = wdata_q[4:0];
      if (sel_irq)   irq_d   = irq_q & ~wdata_q[4:0];
    end
    // Applied after W1C so a simultaneous event on the same bit wins.
    irq_d = irq_d | irq_event_i;
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      size_q   <= 3'd1;
      offset_q <= '0;
      clr_q    <= 1'b0;
      irqen_q  <= '0;
      irq_q    <= '0;
      irq_o_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      offset_q <= offset_d;
      clr_q    <= clr_d;
      irqen_q  <= irqen_d;
      irq_q    <= irq_d;
      irq_o_q  <= irq_o_d;
    end
  end

  assign cfg_size_o   = size_q;
  assign cfg_offset_o = offset_q;
  assign cfg_clr_o    = clr_q;
  assign irq_o        = irq_o_q;

endmodule
